hex_digit_scanner: RTL and testbench

Time-multiplexing sequencer that sits directly upstream of the 4-way N-bit demux. It holds four N-bit digit values and cycles the demux select through digits 0..3 at a programmable rate. It presents each digit's value on `y` with a matching `sel`. A blanking gap between digits prevents ghosting. New values load through a double buffer and swap only at frame boundaries, so a frame never shows a mix of old and new digits.

---
 rtl/hex_digit_scanner_if.sv | 23 ++
 rtl/hex_digit_scanner.sv | 118 +++++++++++
 tb/tb_hex_digit_scanner.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hex_digit_scanner_if.sv
// Digit-scanner bus: shadow-load port in, demux drive (value/select/enable) out.
// master = upstream loader and observer, slave = the scanner itself.
interface hex_digit_scanner_if #(
    parameter int N = 8
);
    logic           load;
    logic [4*N-1:0] data_in;
    logic [N-1:0]   y;
    logic [1:0]     sel;
    logic           en;
    logic           frame_done;
    logic           pending;

    modport master (
        output load, data_in,
        input  y, sel, en, frame_done, pending
    );

    modport slave (
        input  load, data_in,
        output y, sel, en, frame_done, pending
    );
endinterface

// File: rtl/hex_digit_scanner.sv
// Four-digit time-multiplexing sequencer for a 4-way demux.
// Blank gap before each digit; double-buffered digit values swap at frame wrap.
module hex_digit_scanner #(
    parameter int N     = 8,
    parameter int DIV   = 1000,
    parameter int BLANK = 2
) (
    input logic               clk,
    input logic               reset_n,
    hex_digit_scanner_if.slave bus
);
    localparam int MX = (DIV > BLANK) ? DIV : BLANK;
    localparam int CW = (MX > 1) ? $clog2(MX) : 1;

    typedef enum logic {
        ST_BLANK,
        ST_SHOW
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   y_q, y_d;
    logic [1:0]     sel_q, sel_d;
    logic           en_q, en_d;
    logic           fd_q, fd_d;
    logic           pend_q, pend_d;
    logic [4*N-1:0] shadow_q, shadow_d;
    logic [4*N-1:0] active_q, active_d;
    logic [N-1:0]   digit [4];
    logic           wrap;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_BLANK;
            cnt_q    <= '0;
            y_q      <= '0;
            sel_q    <= '0;
            en_q     <= 1'b0;
            fd_q     <= 1'b0;
            pend_q   <= 1'b0;
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            y_q      <= y_d;
            sel_q    <= sel_d;
            en_q     <= en_d;
            fd_q     <= fd_d;
            pend_q   <= pend_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        y_d      = y_q;
        sel_d    = sel_q;
        en_d     = en_q;
        fd_d     = 1'b0;
        pend_d   = pend_q;
        shadow_d = shadow_q;
        active_d = active_q;
        wrap     = 1'b0;
        for (int k = 0; k < 4; k++) begin
            digit[k] = active_q[k*N +: N];
        end

        unique case (state_q)
            ST_BLANK: begin
                if (cnt_q == CW'(BLANK - 1)) begin
                    state_d = ST_SHOW;
                    cnt_d   = '0;
                    en_d    = 1'b1;
                    y_d     = digit[sel_q];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SHOW: begin
                if (cnt_q == CW'(DIV - 1)) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    en_d    = 1'b0;
                    sel_d   = sel_q + 2'd1;
                    wrap    = (sel_q == 2'd3);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase

        // A load landing on the wrap edge goes straight to the display copy.
        if (wrap) begin
            fd_d = 1'b1;
            if (bus.load) begin
                active_d = bus.data_in;
                shadow_d = bus.data_in;
                pend_d   = 1'b0;
            end else if (pend_q) begin
                active_d = shadow_q;
                pend_d   = 1'b0;
            end
        end else if (bus.load) begin
            shadow_d = bus.data_in;
            pend_d   = 1'b1;
        end
    end

    assign bus.y          = y_q;
    assign bus.sel        = sel_q;
    assign bus.en         = en_q;
    assign bus.frame_done = fd_q;
    assign bus.pending    = pend_q;
endmodule

// File: tb/tb_hex_digit_scanner.sv
// Scoreboard bench for hex_digit_scanner: three instances cover scan,
// double buffering, boundary load, async reset and output stability.
module tb_hex_digit_scanner;
    logic clk = 1'b0;
    logic rst_a, rst_b, rst_c;

    always #5 clk = ~clk;

    hex_digit_scanner_if #(.N(8)) ia ();
    hex_digit_scanner_if #(.N(8)) ib ();
    hex_digit_scanner_if #(.N(8)) ic ();

    hex_digit_scanner #(.N(8), .DIV(3), .BLANK(1)) dut_a (
        .clk(clk), .reset_n(rst_a), .bus(ia)
    );
    hex_digit_scanner #(.N(8), .DIV(5), .BLANK(3)) dut_b (
        .clk(clk), .reset_n(rst_b), .bus(ib)
    );
    hex_digit_scanner #(.N(8), .DIV(4), .BLANK(2)) dut_c (
        .clk(clk), .reset_n(rst_c), .bus(ic)
    );

    typedef struct {
        logic [1:0] sel;
        logic [7:0] y;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic push_a(input logic [31:0] d);
        exp_t t;
        for (int k = 0; k < 4; k++) begin
            t.sel = 2'(k);
            t.y   = d[k*8 +: 8];
            qa.push_back(t);
        end
    endtask

    task automatic push_b(input logic [31:0] d);
        exp_t t;
        for (int k = 0; k < 4; k++) begin
            t.sel = 2'(k);
            t.y   = d[k*8 +: 8];
            qb.push_back(t);
        end
    endtask

    task automatic wait_fd_a(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ia.frame_done && n < 24);
        chk(tag, ia.frame_done, 1);
    endtask

    task automatic wait_fd_b(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ib.frame_done && n < 40);
        chk(tag, ib.frame_done, 1);
    endtask

    task automatic wait_fd_c(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ic.frame_done && n < 30);
        chk(tag, ic.frame_done, 1);
    endtask

    // Monitor A: digit scoreboard, frame length, frame_done width
    logic en_pa, fd_pa;
    int   cyc_a;
    bit   seen_a;
    exp_t ea;
    always @(negedge clk) begin
        if (!rst_a) begin
            en_pa  = 1'b0;
            fd_pa  = 1'b0;
            cyc_a  = 0;
            seen_a = 1'b0;
        end else begin
            if (ia.en && !en_pa) begin
                if (qa.size() == 0) begin
                    chk("a_sb_empty", qa.size(), 1);
                end else begin
                    ea = qa.pop_front();
                    chk("a_sel", ia.sel, ea.sel);
                    chk("a_y", ia.y, ea.y);
                end
            end
            cyc_a++;
            if (ia.frame_done) begin
                if (seen_a) chk("a_frame_len", cyc_a, 16);
                chk("a_fd_pulse", fd_pa, 0);
                seen_a = 1'b1;
                cyc_a  = 0;
            end
            en_pa = ia.en;
            fd_pa = ia.frame_done;
        end
    end

    // Monitor B: scoreboard plus y/sel stability rules
    logic       en_pb;
    logic [7:0] y_pb;
    logic [1:0] sel_pb, sel_nx;
    int         cyc_b;
    bit         seen_b;
    exp_t       eb;
    always @(negedge clk) begin
        if (!rst_b) begin
            en_pb  = 1'b0;
            y_pb   = '0;
            sel_pb = '0;
            cyc_b  = 0;
            seen_b = 1'b0;
        end else begin
            sel_nx = sel_pb + 2'd1;
            if (ib.en && !en_pb) begin
                if (qb.size() == 0) begin
                    chk("b_sb_empty", qb.size(), 1);
                end else begin
                    eb = qb.pop_front();
                    chk("b_sel", ib.sel, eb.sel);
                    chk("b_y", ib.y, eb.y);
                end
            end
            if (ib.en && en_pb) begin
                chk("b_y_stable", ib.y, y_pb);
                chk("b_sel_stable", ib.sel, sel_pb);
            end
            if (!ib.en && en_pb) chk("b_sel_inc", ib.sel, sel_nx);
            if (!ib.en && !en_pb) chk("b_sel_hold", ib.sel, sel_pb);
            cyc_b++;
            if (ib.frame_done) begin
                if (seen_b) chk("b_frame_len", cyc_b, 32);
                seen_b = 1'b1;
                cyc_b  = 0;
            end
            en_pb  = ib.en;
            y_pb   = ib.y;
            sel_pb = ib.sel;
        end
    end

    task automatic run_a();
        rst_a      = 1'b0;
        ia.load    = 1'b0;
        ia.data_in = '0;
        push_a(32'h0);
        @(negedge clk);
        rst_a = 1'b1;
        repeat (3) @(negedge clk);
        ia.data_in = {8'd4, 8'd3, 8'd2, 8'd177};
        ia.load    = 1'b1;
        @(negedge clk);
        ia.load = 1'b0;
        chk("a_pend_load", ia.pending, 1);
        wait_fd_a("a_fd0");
        chk("a_pend_swap", ia.pending, 0);
        push_a({8'd4, 8'd3, 8'd2, 8'd177});
        wait_fd_a("a_fd1");
        push_a({8'd4, 8'd3, 8'd2, 8'd177});
        repeat (5) @(negedge clk);
        chk("a_dig1_shown", {ia.en, ia.sel}, 3'b101);
        ia.data_in = {4{8'd9}};
        ia.load    = 1'b1;
        @(negedge clk);
        ia.load = 1'b0;
        chk("a_pend_mid", ia.pending, 1);
        wait_fd_a("a_fd2");
        chk("a_pend_clr9", ia.pending, 0);
        push_a({4{8'd9}});
        repeat (2) @(negedge clk);
        ia.data_in = 32'h11223344;
        ia.load    = 1'b1;
        @(negedge clk);
        ia.load = 1'b0;
        repeat (6) @(negedge clk);
        ia.data_in = 32'hA1B2C3D4;
        ia.load    = 1'b1;
        @(negedge clk);
        ia.load = 1'b0;
        wait_fd_a("a_fd3");
        chk("a_pend_clrB", ia.pending, 0);
        push_a(32'hA1B2C3D4);
        repeat (15) @(negedge clk);
        ia.data_in = 32'h5A6B7C8D;
        ia.load    = 1'b1;
        push_a(32'h5A6B7C8D);
        @(negedge clk);
        ia.load = 1'b0;
        chk("a_fd_coll", ia.frame_done, 1);
        chk("a_pend_coll", ia.pending, 0);
        wait_fd_a("a_fd5");
        chk("a_sb_drain", qa.size(), 0);
        rst_a = 1'b0;
    endtask

    task automatic run_b();
        rst_b      = 1'b0;
        ib.load    = 1'b1;
        ib.data_in = '1;
        push_b(32'h0);
        repeat (2) @(negedge clk);
        chk("b_pend_in_rst", ib.pending, 0);
        ib.load = 1'b0;
        rst_b   = 1'b1;
        repeat (2) @(negedge clk);
        ib.data_in = 32'h0D0C0B0A;
        ib.load    = 1'b1;
        @(negedge clk);
        ib.load = 1'b0;
        wait_fd_b("b_fd0");
        chk("b_pend_swap", ib.pending, 0);
        push_b(32'h0D0C0B0A);
        wait_fd_b("b_fd1");
        push_b(32'h0D0C0B0A);
        wait_fd_b("b_fd2");
        push_b(32'h0D0C0B0A);
        wait_fd_b("b_fd3");
        chk("b_sb_drain", qb.size(), 0);
        rst_b = 1'b0;
    endtask

    task automatic run_c();
        int n = 0;
        rst_c      = 1'b0;
        ic.load    = 1'b0;
        ic.data_in = '0;
        @(negedge clk);
        rst_c = 1'b1;
        @(negedge clk);
        chk("c_en_edge1", ic.en, 0);
        @(negedge clk);
        chk("c_en_edge2", ic.en, 1);
        ic.data_in = {8'd1, 8'd2, 8'd3, 8'd4};
        ic.load    = 1'b1;
        @(negedge clk);
        ic.load = 1'b0;
        wait_fd_c("c_fd0");
        do begin
            @(negedge clk);
            n++;
        end while (!(ic.en && ic.sel == 2'd1) && n < 40);
        chk("c_mid_show", {ic.en, ic.sel}, 3'b101);
        chk("c_y_pre", ic.y, 3);
        ic.data_in = 32'hFFEEDDCC;
        ic.load    = 1'b1;
        @(negedge clk);
        ic.load = 1'b0;
        chk("c_pend_pre", ic.pending, 1);
        #2 rst_c = 1'b0;
        #1;
        chk("c_rst_y", ic.y, 0);
        chk("c_rst_sel", ic.sel, 0);
        chk("c_rst_en", ic.en, 0);
        chk("c_rst_fd", ic.frame_done, 0);
        chk("c_rst_pend", ic.pending, 0);
        @(negedge clk);
        rst_c = 1'b1;
        @(negedge clk);
        chk("c_en2_edge1", ic.en, 0);
        @(negedge clk);
        chk("c_en2_edge2", ic.en, 1);
        chk("c_y_post", ic.y, 0);
        chk("c_pend_post", ic.pending, 0);
    endtask

    initial begin
        fork
            run_a();
            run_b();
            run_c();
        join
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
endmodule
